// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak squeeze datapath.
// Contents: lane/state widths, SHAKE rate depths, squeeze FSM state type and
// the lane_hi() helper locating lane i=5y+x inside the flat 1600-bit state.
package keccak_pkg;

    localparam int unsigned LANE_W         = 64;
    localparam int unsigned STATE_W        = 1600;
    localparam int unsigned RATE_LANES_128 = 21;
    localparam int unsigned RATE_LANES_256 = 17;
    localparam int unsigned LANE_IDX_W     = 5;

    typedef logic [LANE_W-1:0]     lane_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitPerm,
        StStream
    } sqz_state_e;

    // Lane 0 sits in the most significant 64 bits of the state vector.
    function automatic int unsigned lane_hi(input int unsigned i);
        return STATE_W - 1 - LANE_W * i;
    endfunction

endpackage

// File: rtl/keccak_lane_mux.sv
// Combinational N:1 lane selector over the squeeze capture buffer.
// Ports:
//   lanes_i  captured rate lanes
//   sel_i    lane index; out-of-range indices return zero
//   lane_o   selected lane (unregistered; the parent registers it)
module keccak_lane_mux
    import keccak_pkg::*;
#(
    parameter int unsigned NumLanes = RATE_LANES_128
) (
    input  lane_t     lanes_i [NumLanes],
    input  lane_idx_t sel_i,
    output lane_t     lane_o
);

    always_comb begin
        lane_o = '0;
        for (int unsigned i = 0; i < NumLanes; i++) begin
            if (sel_i == lane_idx_t'(i)) begin
                lane_o = lanes_i[i];
            end
        end
    end

endmodule

// File: rtl/keccak_squeezer.sv
// Squeeze-side reader for Keccak-f[1600]: captures a permuted state and
// streams its rate lanes 64 bits at a time, requesting a new permutation when
// the rate is exhausted (continuous SHAKE128/SHAKE256 output).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, rate_sel        open a session; rate_sel 0=SHAKE128, 1=SHAKE256
//   state_in, state_valid  finished permutation and its one-cycle strobe
//   perm_req               one-cycle request for the next permutation
//   out_lane, out_valid,
//   out_ready              registered lane stream, valid/ready handshake
//   stop                   ends the session from any state
//   busy                   high whenever not idle
//   lane_total             accepted lanes this session (KECCAK_SQZ_CNT_EN only)
// Optional feature macro: KECCAK_SQZ_CNT_EN.
module keccak_squeezer
    import keccak_pkg::*;
#(
    parameter int unsigned RATE_LANES_MAX = RATE_LANES_128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rate_sel,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               perm_req,
    output logic [LANE_W-1:0]  out_lane,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               stop,
`ifdef KECCAK_SQZ_CNT_EN
    output logic [31:0]        lane_total,
`endif
    output logic               busy
);

    localparam lane_idx_t LastLane128 = lane_idx_t'(RATE_LANES_128 - 1);
    localparam lane_idx_t LastLane256 = lane_idx_t'(RATE_LANES_256 - 1);

    sqz_state_e state_q, state_d;
    lane_idx_t  lane_cnt_q, lane_cnt_d;
    lane_idx_t  last_lane_q, last_lane_d;
    lane_t      out_lane_q, out_lane_d;
    logic       out_valid_q, out_valid_d;
    logic       perm_req_q, perm_req_d;
    logic       capture;
    logic       handshake;
    lane_idx_t  lane_next;
    lane_t      mux_lane;
    lane_t      lane_buf_q [RATE_LANES_MAX];

    // Capacity lanes beyond the rate are never read out.
    logic unused_capacity;
    assign unused_capacity = ^state_in[LANE_W*(25-RATE_LANES_MAX)-1:0];

    assign handshake = out_valid_q && out_ready;
    assign lane_next = lane_cnt_q + lane_idx_t'(1);

    // Look one lane ahead so the registered output advances on each handshake.
    keccak_lane_mux #(
        .NumLanes (RATE_LANES_MAX)
    ) u_lane_mux (
        .lanes_i (lane_buf_q),
        .sel_i   (lane_next),
        .lane_o  (mux_lane)
    );

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        last_lane_d = last_lane_q;
        out_lane_d  = out_lane_q;
        out_valid_d = out_valid_q;
        perm_req_d  = 1'b0;
        capture     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StWaitPerm;
                    last_lane_d = rate_sel ? LastLane256 : LastLane128;
                    perm_req_d  = 1'b1;
                end
            end
            StWaitPerm: begin
                if (state_valid) begin
                    capture     = 1'b1;
                    lane_cnt_d  = '0;
                    state_d     = StStream;
                    out_valid_d = 1'b1;
                    // Buffer is not yet written, so lane 0 comes straight from the input.
                    out_lane_d  = state_in[lane_hi(0) -: LANE_W];
                end
            end
            StStream: begin
                if (handshake) begin
                    if (lane_cnt_q == last_lane_q) begin
                        state_d     = StWaitPerm;
                        out_valid_d = 1'b0;
                        perm_req_d  = 1'b1;
                    end else begin
                        lane_cnt_d = lane_next;
                        out_lane_d = mux_lane;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // stop overrides everything, including a same-cycle start.
        if (stop) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            perm_req_d  = 1'b0;
            capture     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lane_cnt_q  <= '0;
            last_lane_q <= LastLane128;
            out_lane_q  <= '0;
            out_valid_q <= 1'b0;
            perm_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            last_lane_q <= last_lane_d;
            out_lane_q  <= out_lane_d;
            out_valid_q <= out_valid_d;
            perm_req_q  <= perm_req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < RATE_LANES_MAX; i++) begin
                lane_buf_q[i] <= state_in[lane_hi(i) -: LANE_W];
            end
        end
    end

`ifdef KECCAK_SQZ_CNT_EN
    logic [31:0] lane_total_q;
    logic        start_acc;

    assign start_acc = (state_q == StIdle) && start && !stop;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            lane_total_q <= '0;
        end else if (handshake && (lane_total_q != 32'hFFFF_FFFF)) begin
            lane_total_q <= lane_total_q + 32'd1;
        end
    end

    assign lane_total = lane_total_q;
`endif

    assign out_lane  = out_lane_q;
    assign out_valid = out_valid_q;
    assign perm_req  = perm_req_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/keccak_squeezer.md
Name: keccak_squeezer

Overview:
Squeeze-side reader for the Keccak-f[1600] state, and the consumer at the output end of the permutation datapath. It captures a permuted 1600-bit state, then streams the rate lanes out 64 bits at a time over a valid/ready interface. When the rate is exhausted it requests another permutation, which gives continuous SHAKE128/SHAKE256 output for the Dilithium sampler.

Parameters:
LANE_W, 64, lane width in bits (fixed by Keccak-f[1600]; not meant to be overridden)
STATE_W, 1600, state width in bits
RATE_LANES_MAX, 21, capture-buffer depth in lanes (SHAKE128 rate 1344 bits)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; opens a squeeze session
rate_sel  input  1  0 = SHAKE128 (21 lanes), 1 = SHAKE256 (17 lanes); sampled on accepted start
state_in  input  1600  permuted state; lane i=5y+x at bits [1599-64*i -: 64]
state_valid  input  1  one-cycle pulse; state_in holds a finished permutation
perm_req  output  1  one-cycle pulse requesting the next permutation
out_lane  output  64  current rate lane, bit order as stored in state_in
out_valid  output  1  out_lane valid
out_ready  input  1  consumer accepts out_lane
stop  input  1  ends the session
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - out_valid=0, perm_req=0, busy=0, out_lane=0
  - state=IDLE, lane_cnt=0
- FSM states: IDLE, WAIT_PERM, STREAM.
- IDLE:
  - start -> WAIT_PERM; latch last_lane = rate_sel ? 16 : 20.
  - perm_req pulses in the cycle after start.
- WAIT_PERM:
  - state_valid -> capture lanes 0..20 of state_in into the buffer; lane_cnt=0; -> STREAM.
  - out_valid rises the cycle after state_valid (1-cycle latency) and presents lane 0.
- STREAM:
  - out_valid=1; out_lane = buf[lane_cnt], registered.
  - Handshake is out_valid && out_ready.
  - On handshake with lane_cnt<last_lane: lane_cnt+1, next lane presented the following cycle. Full throughput is 1 lane/cycle.
  - On handshake with lane_cnt==last_lane: -> WAIT_PERM, out_valid=0 next cycle, perm_req pulses next cycle.
  - With out_valid high and out_ready low, out_lane and lane_cnt hold stable.
- Ignored inputs:
  - start while busy is ignored; rate_sel is not re-sampled.
  - state_valid outside WAIT_PERM is ignored; the buffer is not overwritten.
- stop:
  - From any state, stop -> IDLE next cycle; out_valid=0, busy=0, no perm_req.
  - A handshake coinciding with stop counts as delivered.
  - stop beats start in the same cycle.
- reset mid-operation returns to reset values next cycle; the buffer contents are don't-care.
- perm_req is never high for more than one consecutive cycle. There is at most one outstanding request.

Optional Feature:
- Macro: KECCAK_SQZ_CNT_EN.
- When defined:
  - Adds output lane_total [31:0]: number of accepted lanes in the current session.
  - Cleared to 0 on reset and on accepted start; +1 per handshake; saturates at 32'hFFFF_FFFF.
  - Holds its value after stop.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package keccak_pkg:
  - LANE_W, STATE_W
  - RATE_LANES_128=21, RATE_LANES_256=17
  - squeeze FSM state enum
  - lane_hi(i) function returning 1599-64*i
- One sub-module, keccak_lane_mux: combinational 21:1 64-bit lane select indexed by lane_cnt. The parent registers its output.

Test Plan:
1. Reset pulse while streaming -> next cycle out_valid=0, perm_req=0, busy=0, out_lane=0.
2. start, rate_sel=0; perm_req seen; state_valid with lane i = 64'h0101_0101_0101_0100+i; out_ready=1 -> lanes i=0..20 on 21 consecutive cycles, then out_valid=0 and one perm_req pulse.
3. rate_sel=1, same state -> exactly 17 lanes (last value ...0110), then perm_req; lanes 17..20 never appear.
4. Backpressure: out_ready pattern 1,0,0,1,0,1... -> each lane held while stalled; no duplicates or skips; sequence matches test 2.
5. stop asserted during handshake of lane 5 -> lane 5 counted delivered, out_valid=0 and busy=0 next cycle; later state_valid ignored; with KECCAK_SQZ_CNT_EN, lane_total=6.
6. Two permutations: state_valid pulse during STREAM ignored (lanes unchanged); after rollover perm_req, new state_valid -> lane_cnt restarts at 0 with new data; lane_total continues to 42.
